// File: rtl/line_mem_arbiter_pkg.sv
// line_mem_arbiter_pkg: shared FSM/port enums and beat geometry for the line memory arbiter
package line_mem_arbiter_pkg;
  localparam int BEATS = 4;
  localparam int BEAT_IDX_BITS = $clog2(BEATS);
  typedef enum logic [2:0] {IDLE, I_READ, D_READ, D_WRITE, DONE} arb_state_t;
  typedef enum logic {ARB_ICACHE, ARB_DCACHE} arb_port_t;
endpackage

// File: rtl/line_mem_arbiter_burst_line_buffer.sv
// burst_line_buffer: line register + beat counter; loads a whole line, captures/serves one beat per ack (clk, rst, load/line_in, ack/capture/beat_in -> line, beat_out, done)
module burst_line_buffer
  import line_mem_arbiter_pkg::*;
#(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [LINE_BITS-1:0] line_in,
  input  logic                 ack,
  input  logic                 capture,
  input  logic [BEAT_BITS-1:0] beat_in,
  output logic [LINE_BITS-1:0] line,
  output logic [BEAT_BITS-1:0] beat_out,
  output logic                 done
);
  logic [BEAT_IDX_BITS-1:0] beat;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      beat <= '0;
      line <= '0;
    end else begin
      if (load) line <= line_in;
      if (ack) beat <= beat + 1'b1;
      if (ack && capture) line[beat*BEAT_BITS +: BEAT_BITS] <= beat_in;
    end
  assign beat_out = line[beat*BEAT_BITS +: BEAT_BITS];
  assign done = ack && beat == BEAT_IDX_BITS'(BEATS - 1);
endmodule

// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: arbitrates icache/dcache line fills and writebacks onto one 4-beat burst memory port
// Ports: clk, rst (async active-high); i_pmem_* icache side; d_pmem_* dcache side; pmem_* burst memory side.
// Optional macro ARB_ROUND_ROBIN_EN: simultaneous requests go to the port not served last; otherwise dcache wins.
module line_mem_arbiter
  import line_mem_arbiter_pkg::*;
#(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64,
  parameter int ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_pmem_read,
  input  logic [ADDR_BITS-1:0] i_pmem_address,
  output logic [LINE_BITS-1:0] i_pmem_rdata,
  output logic                 i_pmem_resp,
  input  logic                 d_pmem_read,
  input  logic                 d_pmem_write,
  input  logic [ADDR_BITS-1:0] d_pmem_address,
  input  logic [LINE_BITS-1:0] d_pmem_wdata,
  output logic [LINE_BITS-1:0] d_pmem_rdata,
  output logic                 d_pmem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [ADDR_BITS-1:0] pmem_address,
  output logic [BEAT_BITS-1:0] pmem_wdata,
  input  logic [BEAT_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);
  arb_state_t state, state_next;
  arb_port_t owner;
  logic [ADDR_BITS-1:0] addr;
  logic [LINE_BITS-1:0] line;
  logic d_req, grant_d, grant, done;
  assign d_req = d_pmem_read | d_pmem_write;
`ifdef ARB_ROUND_ROBIN_EN
  arb_port_t last;
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= ARB_DCACHE;
    else if (state == DONE) last <= owner;
  // icache overtakes a contending dcache only when dcache had the previous turn
  assign grant_d = d_req && !(i_pmem_read && last == ARB_DCACHE);
`else
  assign grant_d = d_req;
`endif
  assign grant = state == IDLE && (grant_d || i_pmem_read);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  // a simultaneous read+write from dcache is served as the write
  always_comb
    state_next = state == IDLE ? (grant_d ? (d_pmem_write ? D_WRITE : D_READ) : i_pmem_read ? I_READ : IDLE)
               : state == DONE ? IDLE
               : done ? DONE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      owner <= ARB_DCACHE;
    end else if (grant) begin
      addr <= grant_d ? d_pmem_address : i_pmem_address;
      owner <= grant_d ? ARB_DCACHE : ARB_ICACHE;
    end
  always_comb begin
    pmem_read = state == I_READ || state == D_READ;
    pmem_write = state == D_WRITE;
    i_pmem_resp = state == DONE && owner == ARB_ICACHE;
    d_pmem_resp = state == DONE && owner == ARB_DCACHE;
  end
  assign pmem_address = addr;
  assign i_pmem_rdata = line;
  assign d_pmem_rdata = line;
  burst_line_buffer #(.LINE_BITS(LINE_BITS), .BEAT_BITS(BEAT_BITS)) u_buf (
    .clk(clk),
    .rst(rst),
    .load(grant && grant_d && d_pmem_write),
    .line_in(d_pmem_wdata),
    .ack(pmem_resp && (pmem_read || pmem_write)),
    .capture(pmem_read),
    .beat_in(pmem_rdata),
    .line(line),
    .beat_out(pmem_wdata),
    .done(done)
  );
endmodule
